// File: rtl/gcn_io_pkg.sv
// gcn_io_pkg: shared constants and types for the GCN host I/O controller.
//   - default parameter values for gcn_io_ctrl_p
//   - FSM state encodings (4-bit constants)
//   - triple_t: default-width (row, col, data, last) record
//   - idx_w(): index width that never collapses to zero bits
package gcn_io_pkg;

    localparam int DW_DEF      = 16;
    localparam int WROWS_DEF   = 32;
    localparam int NCOL_DEF    = 2;
    localparam int RW_DEF      = 8;
    localparam int CW_DEF      = 8;
    localparam int OUT_LEN_DEF = 200;
    localparam int FDEPTH_DEF  = 4;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_HDR      = 4'd1;
    localparam logic [3:0] S_LOAD_W   = 4'd2;
    localparam logic [3:0] S_LOAD_IN  = 4'd3;
    localparam logic [3:0] S_DRAIN    = 4'd4;
    localparam logic [3:0] S_WAIT     = 4'd5;
    localparam logic [3:0] S_OUT_HDR  = 4'd6;
    localparam logic [3:0] S_OUT_DATA = 4'd7;
    localparam logic [3:0] S_OUT_TAIL = 4'd8;

    typedef struct packed {
        logic [RW_DEF-1:0] row;
        logic [CW_DEF-1:0] col;
        logic [DW_DEF-1:0] data;
        logic              last;
    } triple_t;

    // A counter over n values needs $clog2(n) bits, but n==1 would give 0.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gcn_io_fifo.sv
// gcn_io_fifo: synchronous FIFO of input triples.
//   clk/rst        clock, async active-low reset (flushes pointers)
//   push_i, din_i  write side; a push while full succeeds only if pop_i is also set
//   pop_i          read side; ignored while empty
//   dout_o         head entry, stable until popped
//   full_o/empty_o occupancy flags
module gcn_io_fifo
    import gcn_io_pkg::*;
#(
    parameter type T     = triple_t,
    parameter int  DEPTH = FDEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     din_i,
    input  logic pop_i,
    output T     dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [PW-1:0]  wp_q, rp_q;
    logic [PW:0]    cnt_q;
    logic           wr, rd;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign rd      = pop_i && !empty_o;
    // The entry being popped frees its slot in the same cycle.
    assign wr      = push_i && (!full_o || rd);
    assign dout_o  = mem_q[rp_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + PW'(1);
            if (rd) rp_q <= rp_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(wr) - (PW+1)'(rd);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= din_i;
    end

endmodule

// File: rtl/gcn_io_ctrl_p.sv
// gcn_io_ctrl_p: host-side I/O sequencer for the GCN accelerator.
//   i_req/i_cmd/i_pad  host input: header, NCOL*WROWS weight words, then
//                      A/B word pairs forming (row, col, data, last) triples
//   o_w_*              weight-buffer write port (combinational in LOAD_W)
//   o_in_* / i_in_ready triple stream to Scheduler1 from the FIFO head
//   i_done             compute-complete pulse, honoured only in WAIT
//   o_rd_* / i_rd_data result-memory read port (1-cycle read latency)
//   o_pad/o_valid      registered output stream: header then OUT_LEN words per column
//   o_result           host may idle (IDLE or WAIT)
//   o_rdy              one-cycle pulse the cycle after the final output word
//   o_ovf              sticky triple-drop flag
module gcn_io_ctrl_p
    import gcn_io_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int WROWS   = WROWS_DEF,
    parameter int NCOL    = NCOL_DEF,
    parameter int RW      = RW_DEF,
    parameter int CW      = CW_DEF,
    parameter int OUT_LEN = OUT_LEN_DEF,
    parameter int FDEPTH  = FDEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_req,
    input  logic                        i_cmd,
    input  logic [DW-1:0]               i_pad,
    output logic [DW-1:0]               o_pad,
    output logic                        o_valid,
    output logic                        o_result,
    output logic                        o_rdy,
    output logic                        o_ovf,
    output logic                        o_w_we,
    output logic [idx_w(NCOL)-1:0]      o_w_col,
    output logic [idx_w(WROWS)-1:0]     o_w_row,
    output logic [DW-1:0]               o_w_data,
    output logic                        o_in_valid,
    output logic [RW-1:0]               o_in_row,
    output logic [CW-1:0]               o_in_col,
    output logic [DW-1:0]               o_in_data,
    output logic                        o_in_last,
    input  logic                        i_in_ready,
    input  logic                        i_done,
    output logic                        o_rd_en,
    output logic [idx_w(OUT_LEN)-1:0]   o_rd_addr,
    output logic [idx_w(NCOL)-1:0]      o_rd_col,
    input  logic [DW-1:0]               i_rd_data
);
    localparam int CBW = idx_w(NCOL);
    localparam int RBW = idx_w(WROWS);
    localparam int ABW = idx_w(OUT_LEN);
    localparam logic [CBW-1:0] CLAST = CBW'(NCOL - 1);
    localparam logic [RBW-1:0] RLAST = RBW'(WROWS - 1);
    localparam logic [ABW-1:0] ALAST = ABW'(OUT_LEN - 1);

    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [DW-1:0] data;
        logic          last;
    } trip_t;

    logic [3:0]     state_q, state_d;
    logic [CW-1:0]  base_q, base_d;
    logic [RBW-1:0] rcnt_q, rcnt_d;
    logic [CBW-1:0] ccnt_q, ccnt_d, c_q, c_d;
    logic [ABW-1:0] addr_q, addr_d;
    logic           phase_q, phase_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic           rdy_pend_d, rdy_pend_q;
    logic [DW-1:0]  pad_d, pad_q;
    logic           valid_d, valid_q;
    logic           rdv_q, rdy_q, ovf_q;
    logic [CW-1:0]  hdr;
    logic           push, pop, full, empty;
    trip_t          push_t, head_t;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rcnt_d     = rcnt_q;
        ccnt_d     = ccnt_q;
        c_d        = c_q;
        addr_d     = addr_q;
        phase_d    = phase_q;
        row_d      = row_q;
        col_d      = col_q;
        rdy_pend_d = 1'b0;
        push       = 1'b0;
        case (state_q)
            S_IDLE:    if (i_req) state_d = S_HDR;
            S_HDR: begin
                base_d  = i_pad[CW-1:0];
                rcnt_d  = '0;
                ccnt_d  = '0;
                state_d = S_LOAD_W;
            end
            S_LOAD_W: begin
                if (rcnt_q == RLAST) begin
                    rcnt_d = '0;
                    if (ccnt_q == CLAST) begin
                        phase_d = 1'b0;
                        state_d = S_LOAD_IN;
                    end else begin
                        ccnt_d = ccnt_q + CBW'(1);
                    end
                end else begin
                    rcnt_d = rcnt_q + RBW'(1);
                end
            end
            S_LOAD_IN: begin
                phase_d = !phase_q;
                if (!phase_q) begin
                    row_d = i_pad[DW-1:DW-RW];
                    col_d = i_pad[CW-1:0];
                end else begin
                    push = 1'b1;
                    if (i_cmd) state_d = S_DRAIN;
                end
            end
            S_DRAIN:   if (empty) state_d = S_WAIT;
            S_WAIT: begin
                if (i_done) begin
                    c_d     = '0;
                    state_d = S_OUT_HDR;
                end
            end
            S_OUT_HDR: begin
                addr_d  = '0;
                state_d = S_OUT_DATA;
            end
            S_OUT_DATA: begin
                if (addr_q == ALAST) state_d = S_OUT_TAIL;
                else                 addr_d  = addr_q + ABW'(1);
            end
            S_OUT_TAIL: begin
                if (c_q == CLAST) begin
                    rdy_pend_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    c_d     = c_q + CBW'(1);
                    state_d = S_OUT_HDR;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Output word mux: header in OUT_HDR, else read data one cycle after o_rd_en.
    assign hdr = base_q + CW'(c_q);
    always_comb begin
        pad_d   = '0;
        valid_d = 1'b0;
        if (state_q == S_OUT_HDR) begin
            pad_d   = DW'(hdr);
            valid_d = 1'b1;
        end else if (rdv_q) begin
            pad_d   = i_rd_data;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            rcnt_q     <= '0;
            ccnt_q     <= '0;
            c_q        <= '0;
            addr_q     <= '0;
            phase_q    <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            rdy_pend_q <= 1'b0;
            rdy_q      <= 1'b0;
            rdv_q      <= 1'b0;
            pad_q      <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            rcnt_q     <= rcnt_d;
            ccnt_q     <= ccnt_d;
            c_q        <= c_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rdy_pend_q <= rdy_pend_d;
            rdy_q      <= rdy_pend_q;
            rdv_q      <= (state_q == S_OUT_DATA);
            pad_q      <= pad_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_q | (push && full && !pop);
        end
    end

    always_comb begin
        push_t.row  = row_q;
        push_t.col  = col_q;
        push_t.data = i_pad;
        push_t.last = i_cmd;
    end

    assign pop = o_in_valid && i_in_ready;

    gcn_io_fifo #(.T(trip_t), .DEPTH(FDEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_t),
        .pop_i   (pop),
        .dout_o  (head_t),
        .full_o  (full),
        .empty_o (empty)
    );

    assign o_in_valid = !empty;
    assign o_in_row   = head_t.row;
    assign o_in_col   = head_t.col;
    assign o_in_data  = head_t.data;
    assign o_in_last  = head_t.last;

    assign o_w_we    = (state_q == S_LOAD_W);
    assign o_w_data  = o_w_we ? i_pad  : '0;
    assign o_w_row   = o_w_we ? rcnt_q : '0;
    assign o_w_col   = o_w_we ? ccnt_q : '0;

    assign o_rd_en   = (state_q == S_OUT_DATA);
    assign o_rd_addr = o_rd_en ? addr_q : '0;
    assign o_rd_col  = o_rd_en ? c_q    : '0;

    assign o_pad     = pad_q;
    assign o_valid   = valid_q;
    assign o_rdy     = rdy_q;
    assign o_ovf     = ovf_q;
    assign o_result  = (state_q == S_IDLE) || (state_q == S_WAIT);

endmodule

// File: tb/tb_gcn_io_ctrl_p.sv
// tb_gcn_io_ctrl_p: scoreboard bench for gcn_io_ctrl_p (NCOL=2, WROWS=32,
// OUT_LEN=3, FDEPTH=4). Expected weight writes, triples and output words are
// queued as stimulus is driven and checked by a negedge monitor.
module tb_gcn_io_ctrl_p;
    import gcn_io_pkg::*;

    localparam int DW = 16, WROWS = 32, NCOL = 2, RW = 8, CW = 8, OUT_LEN = 3, FDEPTH = 4;
    localparam int CBW = idx_w(NCOL), RBW = idx_w(WROWS), ABW = idx_w(OUT_LEN);

    logic clk, rst, i_req, i_cmd, i_in_ready, i_done;
    logic [DW-1:0] i_pad, i_rd_data;
    logic [DW-1:0] o_pad, o_w_data, o_in_data;
    logic o_valid, o_result, o_rdy, o_ovf, o_w_we, o_in_valid, o_in_last, o_rd_en;
    logic [CBW-1:0] o_w_col, o_rd_col;
    logic [RBW-1:0] o_w_row;
    logic [RW-1:0] o_in_row;
    logic [CW-1:0] o_in_col;
    logic [ABW-1:0] o_rd_addr;

    gcn_io_ctrl_p #(.DW(DW), .WROWS(WROWS), .NCOL(NCOL), .RW(RW), .CW(CW),
                    .OUT_LEN(OUT_LEN), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_cmd(i_cmd), .i_pad(i_pad),
        .o_pad(o_pad), .o_valid(o_valid), .o_result(o_result), .o_rdy(o_rdy), .o_ovf(o_ovf),
        .o_w_we(o_w_we), .o_w_col(o_w_col), .o_w_row(o_w_row), .o_w_data(o_w_data),
        .o_in_valid(o_in_valid), .o_in_row(o_in_row), .o_in_col(o_in_col),
        .o_in_data(o_in_data), .o_in_last(o_in_last), .i_in_ready(i_in_ready),
        .i_done(i_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_rd_col(o_rd_col),
        .i_rd_data(i_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Result memory model: data = addr + 0x10*col, one cycle after the read.
    always @(posedge clk)
        i_rd_data <= o_rd_en ? (DW'(o_rd_addr) + DW'(o_rd_col) * 16'h0010) : '0;

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct { logic [15:0] d; int off; } oexp_t;
    logic [CBW+RBW+DW-1:0] wq[$];
    logic [RW+CW+DW:0]     tq[$];
    oexp_t                 oq[$];
    oexp_t                 oe;
    int nw = 0, nrdy = 0, t_base = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (o_w_we) begin
                nw++;
                if (wq.size() == 0) chk("w_extra", 64'(o_w_we), 64'(0));
                else chk("w_write", 64'({o_w_col, o_w_row, o_w_data}), 64'(wq.pop_front()));
            end
            if (o_in_valid && i_in_ready) begin
                if (tq.size() == 0) chk("t_extra", 64'(o_in_valid), 64'(0));
                else chk("triple", 64'({o_in_row, o_in_col, o_in_data, o_in_last}), 64'(tq.pop_front()));
            end
            if (o_valid) begin
                if (oq.size() == 0) chk("o_extra", 64'(o_valid), 64'(0));
                else begin
                    oe = oq.pop_front();
                    if (oe.off == 0) t_base = cyc;
                    chk("o_pad", 64'(o_pad), 64'(oe.d));
                    chk("o_cycle", 64'(cyc - t_base), 64'(oe.off));
                end
            end
            if (o_rdy) nrdy++;
        end
    end

    task automatic step(input logic req, input logic cmd, input logic [15:0] pad);
        i_req = req; i_cmd = cmd; i_pad = pad;
        @(posedge clk); #1;
    endtask

    task automatic load_w(input logic [7:0] base, input logic [15:0] dbase);
        int n0;
        step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, {8'h00, base});
        n0 = nw;
        for (int k = 0; k < NCOL*WROWS; k++) begin
            wq.push_back({CBW'(k / WROWS), RBW'(k % WROWS), 16'(dbase + 16'(k))});
            // stray i_req / i_cmd while loading must be ignored
            step(k == 10, k == 20, dbase + 16'(k));
        end
        chk("st_loadin", 64'(dut.state_q), 64'(S_LOAD_IN));
        chk("w_count", 64'(nw - n0), 64'(NCOL*WROWS));
    endtask

    task automatic wait_result(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (o_result) break;
            step(1'b0, 1'b0, 16'h0);
        end
        chk(tag, 64'(o_result), 64'(1));
        chk({tag, "_st"}, 64'(dut.state_q), 64'(S_WAIT));
    endtask

    task automatic run_out(input logic [7:0] base);
        logic got;
        int rc, r0;
        for (int c = 0; c < NCOL; c++) begin
            oq.push_back('{d: 16'(8'(int'(base) + c)), off: c*(OUT_LEN+2)});
            for (int k = 0; k < OUT_LEN; k++)
                oq.push_back('{d: 16'(k + 16*c), off: c*(OUT_LEN+2) + 2 + k});
        end
        r0 = nrdy;
        i_done = 1'b1; step(1'b0, 1'b0, 16'h0); i_done = 1'b0;
        got = 1'b0; rc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_rdy) begin got = 1'b1; rc = cyc; break; end
        end
        chk("rdy_seen", 64'(got), 64'(1));
        if (got) chk("rdy_cycle", 64'(rc - t_base), 64'(NCOL*(OUT_LEN+2)));
        @(posedge clk); #1;
        repeat (3) step(1'b0, 1'b0, 16'h0);
        chk("rdy_pulses", 64'(nrdy - r0), 64'(1));
        chk("out_drained", 64'(oq.size()), 64'(0));
    endtask

    initial begin
        int r0;
        rst = 1'b0; i_req = 1'b0; i_cmd = 1'b0; i_pad = '0; i_in_ready = 1'b0; i_done = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("rst_pad", 64'(o_pad), 64'(0));
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_result", 64'(o_result), 64'(1));
        chk("rst_rdy", 64'(o_rdy), 64'(0));
        chk("rst_ovf", 64'(o_ovf), 64'(0));
        chk("rst_in_valid", 64'(o_in_valid), 64'(0));
        rst = 1'b1;
        step(1'b0, 1'b0, 16'h0);

        // Transfer 1: weights, two triples with ready high, outputs for base 4
        i_in_ready = 1'b1;
        load_w(8'h04, 16'h0000);
        i_done = 1'b1;
        step(1'b0, 1'b1, 16'h0305);            // i_cmd on word A, i_done in LOAD_IN
        i_done = 1'b0;
        tq.push_back({8'd3, 8'd5, 16'h1234, 1'b0});
        step(1'b0, 1'b0, 16'h1234);
        tq.push_back({8'd4, 8'd7, 16'hBEEF, 1'b1});
        step(1'b0, 1'b0, 16'h0407);
        step(1'b0, 1'b1, 16'hBEEF);
        wait_result("wait1");
        chk("t1_drained", 64'(tq.size()), 64'(0));
        chk("no_early_out", 64'(o_valid), 64'(0));
        run_out(8'h04);

        // Transfer 2: backpressure and overflow, then reset mid-output
        i_in_ready = 1'b0;
        load_w(8'h04, 16'h0100);
        for (int i = 0; i < 5; i++) begin
            if (i < FDEPTH) tq.push_back({8'(i+1), 8'(8'h20+i), 16'(16'hA000+i), 1'b0});
            step(1'b0, 1'b0, {8'(i+1), 8'(8'h20+i)});
            if (i == 4) chk("ovf_before", 64'(o_ovf), 64'(0));
            step(1'b0, i == 4, 16'(16'hA000 + i));
        end
        chk("ovf_set", 64'(o_ovf), 64'(1));
        chk("stall_head", 64'({o_in_valid, o_in_row, o_in_col, o_in_data, o_in_last}),
            64'({1'b1, 8'd1, 8'h20, 16'hA000, 1'b0}));
        repeat (3) step(1'b0, 1'b0, 16'h0);
        chk("stall_hold", 64'({o_in_row, o_in_col, o_in_data}), 64'({8'd1, 8'h20, 16'hA000}));
        i_in_ready = 1'b1;
        wait_result("wait2");
        chk("ovf_sticky", 64'(o_ovf), 64'(1));
        chk("t2_drained", 64'(tq.size()), 64'(0));

        oq.push_back('{d: 16'h0004, off: 0});
        i_done = 1'b1; step(1'b0, 1'b0, 16'h0); i_done = 1'b0;
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("mid_rd_en", 64'(o_rd_en), 64'(1));
        r0 = nrdy;
        rst = 1'b0; #1;
        chk("arst_valid", 64'(o_valid), 64'(0));
        chk("arst_pad", 64'(o_pad), 64'(0));
        chk("arst_rd_en", 64'(o_rd_en), 64'(0));
        chk("arst_result", 64'(o_result), 64'(1));
        chk("arst_ovf", 64'(o_ovf), 64'(0));
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (12) step(1'b0, 1'b0, 16'h0);
        chk("abort_no_rdy", 64'(nrdy - r0), 64'(0));
        chk("abort_hdr_seen", 64'(oq.size()), 64'(0));

        // Transfer 3: fresh request after the abort, base 9
        load_w(8'h09, 16'h0200);
        tq.push_back({8'd1, 8'd2, 16'h5555, 1'b1});
        step(1'b0, 1'b0, 16'h0102);
        step(1'b0, 1'b1, 16'h5555);
        wait_result("wait3");
        run_out(8'h09);

        chk("wq_empty", 64'(wq.size()), 64'(0));
        chk("tq_empty", 64'(tq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
